// File: rtl/onewire_slave.sv
// 1-wire slave endpoint: reset/presence handling, write-slot deserialisation and
// LSB-first read-slot transmission with wired-AND readback on the shared line.
module onewire_slave #(
    parameter int CW     = 16,
    parameter int T_RSTD = 400,
    parameter int T_PDH  = 15,
    parameter int T_PDL  = 120,
    parameter int T_SMP  = 30,
    parameter int T_TX0  = 45
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        owr,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    input  logic [7:0] tx_dat,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       rst_det
);

    typedef enum logic [2:0] {
        IDLE,
        SLOT,
        RST_LOW,
        PD_WAIT,
        PD_LOW
    } state_t;

    localparam logic [CW-1:0] SMP_AT    = CW'(T_SMP);
    localparam logic [CW-1:0] RSTD_AT   = CW'(T_RSTD);
    localparam logic [CW-1:0] TX0_LAST  = CW'(T_TX0 - 1);
    localparam logic [CW-1:0] PDH_LAST  = CW'(T_PDH - 1);
    localparam logic [CW-1:0] PDL_LAST  = CW'(T_PDL - 1);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    rx_sh_reg;
    logic [7:0]    rx_sh_next;
    logic [7:0]    tx_byte_reg;
    logic          armed_reg;
    logic          tx_act_reg;
    logic          pull_reg;
    logic [1:0]    sync_reg;
    logic          prev_reg;

    logic line;
    logic fall;
    logic drive_next;
    logic tx_bit;

    assign owr = pull_reg ? 1'b0 : 1'bz;

    assign line       = sync_reg[1];
    assign fall       = prev_reg & ~line;
    assign cnt_next   = (&cnt_reg) ? cnt_reg : cnt_reg + CW'(1);
    assign rx_sh_next = {line, rx_sh_reg[7:1]};
    assign tx_bit     = tx_byte_reg[bit_cnt_reg];
    // A byte armed mid-byte only starts driving once the bit counter is back at 0.
    assign drive_next = (bit_cnt_reg == 3'd0) ? armed_reg : tx_act_reg;
    assign tx_rdy     = ~armed_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            rx_sh_reg   <= '0;
            tx_byte_reg <= '0;
            armed_reg   <= 1'b0;
            tx_act_reg  <= 1'b0;
            pull_reg    <= 1'b0;
            sync_reg    <= 2'b11;
            prev_reg    <= 1'b1;
            rx_dat      <= '0;
            rx_vld      <= 1'b0;
            rst_det     <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], owr};
            prev_reg <= line;
            rx_vld   <= 1'b0;
            rst_det  <= 1'b0;

            if (tx_vld && !armed_reg) begin
                armed_reg   <= 1'b1;
                tx_byte_reg <= tx_dat;
            end

            case (state_reg)
                IDLE: begin
                    if (fall) begin
                        state_reg <= SLOT;
                        cnt_reg   <= '0;
                        if (bit_cnt_reg == 3'd0) begin
                            tx_act_reg <= armed_reg;
                        end
                        pull_reg <= drive_next & ~tx_bit;
                    end
                end

                SLOT: begin
                    cnt_reg <= cnt_next;
                    if (pull_reg && cnt_reg == TX0_LAST) begin
                        pull_reg <= 1'b0;
                    end
                    if (cnt_reg == SMP_AT) begin
                        rx_sh_reg   <= rx_sh_next;
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_dat <= rx_sh_next;
                            rx_vld <= 1'b1;
                            if (tx_act_reg) begin
                                armed_reg  <= 1'b0;
                                tx_act_reg <= 1'b0;
                            end
                        end
                    end else if (cnt_reg > SMP_AT && !pull_reg && line) begin
                        state_reg <= IDLE;
                    end else if (!line && cnt_reg >= RSTD_AT) begin
                        // Reset low: abandon the partial byte and any armed transmit.
                        state_reg   <= RST_LOW;
                        rst_det     <= 1'b1;
                        bit_cnt_reg <= '0;
                        rx_sh_reg   <= '0;
                        armed_reg   <= 1'b0;
                        tx_act_reg  <= 1'b0;
                        pull_reg    <= 1'b0;
                    end
                end

                RST_LOW: begin
                    if (line) begin
                        state_reg <= PD_WAIT;
                        cnt_reg   <= '0;
                    end
                end

                PD_WAIT: begin
                    cnt_reg <= cnt_next;
                    if (cnt_reg == PDH_LAST) begin
                        state_reg <= PD_LOW;
                        cnt_reg   <= '0;
                        pull_reg  <= 1'b1;
                    end
                end

                PD_LOW: begin
                    cnt_reg <= cnt_next;
                    if (cnt_reg == PDL_LAST) begin
                        state_reg <= IDLE;
                        pull_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    pull_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_slave.sv
// Directed bench for onewire_slave: a behavioural 1-wire master drives the shared
// pulled-up line and each scenario task checks its own expected values.
module tb_onewire_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    wire        owr;
    logic       master_pull = 1'b0;
    logic [7:0] rx_dat;
    logic       rx_vld;
    logic [7:0] tx_dat = 8'h00;
    logic       tx_vld = 1'b0;
    logic       tx_rdy;
    logic       rst_det;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int         rxv_cnt = 0;
    int         rstd_cnt = 0;
    int         rstd_cyc = 0;
    int         slave_low_cnt = 0;
    logic [7:0] rx_last = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pullup (owr);
    assign owr = master_pull ? 1'b0 : 1'bz;

    onewire_slave dut (
        .clk     (clk),
        .rst     (rst),
        .owr     (owr),
        .rx_dat  (rx_dat),
        .rx_vld  (rx_vld),
        .tx_dat  (tx_dat),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .rst_det (rst_det)
    );

    // Event monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rx_vld === 1'b1) begin
            rxv_cnt = rxv_cnt + 1;
            rx_last = rx_dat;
        end
        if (rst_det === 1'b1) begin
            rstd_cnt = rstd_cnt + 1;
            rstd_cyc = cyc;
        end
        if (owr === 1'b0 && !master_pull) slave_low_cnt = slave_low_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        rxv_cnt = 0;
        rstd_cnt = 0;
        slave_low_cnt = 0;
    endtask

    task automatic write_bit(input logic b);
        master_pull = 1'b1;
        tick(b ? 5 : 60);
        master_pull = 1'b0;
        tick(b ? 60 : 5);
    endtask

    task automatic write_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) write_bit(d[i]);
    endtask

    task automatic read_bit(output logic b);
        master_pull = 1'b1;
        tick(2);
        master_pull = 1'b0;
        tick(13);
        b = (owr === 1'b0) ? 1'b0 : 1'b1;
        tick(55);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    task automatic arm(input logic [7:0] d);
        tx_dat = d;
        tx_vld = 1'b1;
        tick(1);
        tx_vld = 1'b0;
    endtask

    task automatic master_reset();
        master_pull = 1'b1;
        tick(480);
        master_pull = 1'b0;
        tick(200);
    endtask

    task automatic test_reset();
        tick(3);
        n_cmp++; if (rx_dat !== 8'h00) begin n_bad++; $display("FAIL rst_rx_dat: got %h want 00", rx_dat); end
        n_cmp++; if (rx_vld !== 1'b0) begin n_bad++; $display("FAIL rst_rx_vld: got %b want 0", rx_vld); end
        n_cmp++; if (tx_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_tx_rdy: got %b want 1", tx_rdy); end
        n_cmp++; if (rst_det !== 1'b0) begin n_bad++; $display("FAIL rst_rst_det: got %b want 0", rst_det); end
        rst = 1'b0;
        tick(5);
        n_cmp++; if (owr !== 1'b1) begin n_bad++; $display("FAIL rst_owr: got %b want 1", owr); end
        $display("reset released");
    endtask

    task automatic test_reset_presence();
        int c0;
        int first;
        int low;
        logic samp;
        first = -1;
        low = 0;
        samp = 1'b1;
        clear_mon();
        c0 = cyc;
        master_pull = 1'b1;
        tick(480);
        master_pull = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (owr === 1'b0) begin
                if (first < 0) first = i;
                low++;
            end
            if (i == 75) samp = owr;
        end
        $display("bus reset: rst_det at +%0d, presence at +%0d for %0d", rstd_cyc - c0, first, low);
        n_cmp++; if (rstd_cnt !== 1) begin n_bad++; $display("FAIL pres_rst_det_cnt: got %0d want 1", rstd_cnt); end
        n_cmp++; if (rstd_cyc - c0 < 400 || rstd_cyc - c0 > 406) begin n_bad++; $display("FAIL pres_rst_det_time: got %0d want 400..406", rstd_cyc - c0); end
        n_cmp++; if (first < 15 || first > 20) begin n_bad++; $display("FAIL pres_start: got %0d want 15..20", first); end
        n_cmp++; if (low !== 120) begin n_bad++; $display("FAIL pres_len: got %0d want 120", low); end
        n_cmp++; if (samp !== 1'b0) begin n_bad++; $display("FAIL pres_sample75: got %b want 0", samp); end
        n_cmp++; if (rxv_cnt !== 0) begin n_bad++; $display("FAIL pres_rx_vld: got %0d want 0", rxv_cnt); end
    endtask

    task automatic test_write_byte();
        clear_mon();
        write_byte(8'hA5);
        tick(5);
        $display("master write a5 -> rx %h (%0d pulses)", rx_last, rxv_cnt);
        n_cmp++; if (rxv_cnt !== 1) begin n_bad++; $display("FAIL wr_vld_cnt: got %0d want 1", rxv_cnt); end
        n_cmp++; if (rx_last !== 8'hA5) begin n_bad++; $display("FAIL wr_rx_dat: got %h want a5", rx_last); end
        n_cmp++; if (slave_low_cnt !== 0) begin n_bad++; $display("FAIL wr_no_pull: got %0d want 0", slave_low_cnt); end
    endtask

    task automatic test_tx_read();
        logic [7:0] d;
        logic b;
        d = 8'h00;
        clear_mon();
        arm(8'h3C);
        n_cmp++; if (tx_rdy !== 1'b0) begin n_bad++; $display("FAIL tx_rdy_drop: got %b want 0", tx_rdy); end
        for (int i = 0; i < 7; i++) begin
            read_bit(b);
            d[i] = b;
        end
        n_cmp++; if (tx_rdy !== 1'b0) begin n_bad++; $display("FAIL tx_rdy_bit6: got %b want 0", tx_rdy); end
        read_bit(b);
        d[7] = b;
        $display("master read -> %h, rx %h", d, rx_last);
        n_cmp++; if (tx_rdy !== 1'b1) begin n_bad++; $display("FAIL tx_rdy_after: got %b want 1", tx_rdy); end
        n_cmp++; if (d !== 8'h3C) begin n_bad++; $display("FAIL tx_master_read: got %h want 3c", d); end
        n_cmp++; if (rxv_cnt !== 1) begin n_bad++; $display("FAIL tx_vld_cnt: got %0d want 1", rxv_cnt); end
        n_cmp++; if (rx_last !== 8'h3C) begin n_bad++; $display("FAIL tx_readback: got %h want 3c", rx_last); end
    endtask

    task automatic test_arm_midbyte(input logic [7:0] tx_byte, input logic [7:0] first,
                                    input logic [7:0] second, input logic rd,
                                    input logic [7:0] exp2);
        logic [7:0] d;
        clear_mon();
        for (int i = 0; i < 3; i++) write_bit(first[i]);
        arm(tx_byte);
        for (int i = 3; i < 8; i++) write_bit(first[i]);
        $display("mid-byte arm %h: first byte rx %h", tx_byte, rx_last);
        n_cmp++; if (rxv_cnt !== 1) begin n_bad++; $display("FAIL mid_vld1: got %0d want 1", rxv_cnt); end
        n_cmp++; if (rx_last !== first) begin n_bad++; $display("FAIL mid_rx1: got %h want %h", rx_last, first); end
        n_cmp++; if (tx_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_rdy1: got %b want 0", tx_rdy); end
        if (rd) begin
            read_byte(d);
            n_cmp++; if (d !== exp2) begin n_bad++; $display("FAIL mid_read2: got %h want %h", d, exp2); end
        end else begin
            write_byte(second);
        end
        $display("mid-byte arm %h: second byte rx %h", tx_byte, rx_last);
        n_cmp++; if (rxv_cnt !== 2) begin n_bad++; $display("FAIL mid_vld2: got %0d want 2", rxv_cnt); end
        n_cmp++; if (rx_last !== exp2) begin n_bad++; $display("FAIL mid_rx2: got %h want %h", rx_last, exp2); end
        n_cmp++; if (tx_rdy !== 1'b1) begin n_bad++; $display("FAIL mid_rdy2: got %b want 1", tx_rdy); end
    endtask

    task automatic test_reset_abort();
        logic b;
        logic [3:0] d;
        d = 4'h0;
        clear_mon();
        arm(8'h0F);
        for (int i = 0; i < 4; i++) begin
            read_bit(b);
            d[i] = b;
        end
        n_cmp++; if (d !== 4'hF) begin n_bad++; $display("FAIL abort_read4: got %h want f", d); end
        n_cmp++; if (tx_rdy !== 1'b0) begin n_bad++; $display("FAIL abort_rdy_pre: got %b want 0", tx_rdy); end
        master_reset();
        $display("reset after 4 bits: rst_det %0d, rx_vld %0d", rstd_cnt, rxv_cnt);
        n_cmp++; if (rstd_cnt !== 1) begin n_bad++; $display("FAIL abort_rst_det: got %0d want 1", rstd_cnt); end
        n_cmp++; if (rxv_cnt !== 0) begin n_bad++; $display("FAIL abort_no_vld: got %0d want 0", rxv_cnt); end
        n_cmp++; if (tx_rdy !== 1'b1) begin n_bad++; $display("FAIL abort_rdy_post: got %b want 1", tx_rdy); end
        write_byte(8'h3A);
        $display("master write 3a after reset -> rx %h", rx_last);
        n_cmp++; if (rxv_cnt !== 1) begin n_bad++; $display("FAIL abort_vld_next: got %0d want 1", rxv_cnt); end
        n_cmp++; if (rx_last !== 8'h3A) begin n_bad++; $display("FAIL abort_rx_next: got %h want 3a", rx_last); end
        clear_mon();
        master_pull = 1'b1;
        tick(300);
        master_pull = 1'b0;
        tick(5);
        for (int i = 1; i < 8; i++) write_bit(1'b1);
        $display("300-cycle low + 7 ones -> rx %h", rx_last);
        n_cmp++; if (rstd_cnt !== 0) begin n_bad++; $display("FAIL long_no_rst_det: got %0d want 0", rstd_cnt); end
        n_cmp++; if (rxv_cnt !== 1) begin n_bad++; $display("FAIL long_vld: got %0d want 1", rxv_cnt); end
        n_cmp++; if (rx_last !== 8'hFE) begin n_bad++; $display("FAIL long_rx: got %h want fe", rx_last); end
    endtask

    task automatic test_async_rst();
        clear_mon();
        master_pull = 1'b1;
        tick(480);
        master_pull = 1'b0;
        tick(40);
        n_cmp++; if (owr !== 1'b0) begin n_bad++; $display("FAIL arst_presence: got %b want 0", owr); end
        rst = 1'b1;
        #1;
        n_cmp++; if (owr !== 1'b1) begin n_bad++; $display("FAIL arst_release: got %b want 1", owr); end
        tick(3);
        rst = 1'b0;
        tick(1);
        n_cmp++; if (rx_dat !== 8'h00) begin n_bad++; $display("FAIL arst_rx_dat: got %h want 00", rx_dat); end
        n_cmp++; if (rx_vld !== 1'b0) begin n_bad++; $display("FAIL arst_rx_vld: got %b want 0", rx_vld); end
        n_cmp++; if (tx_rdy !== 1'b1) begin n_bad++; $display("FAIL arst_tx_rdy: got %b want 1", tx_rdy); end
        n_cmp++; if (rst_det !== 1'b0) begin n_bad++; $display("FAIL arst_rst_det: got %b want 0", rst_det); end
        clear_mon();
        tick(150);
        n_cmp++; if (slave_low_cnt !== 0) begin n_bad++; $display("FAIL arst_idle_line: got %0d want 0", slave_low_cnt); end
        write_byte(8'h5C);
        $display("after async reset: master write 5c -> rx %h", rx_last);
        n_cmp++; if (rxv_cnt !== 1) begin n_bad++; $display("FAIL arst_vld: got %0d want 1", rxv_cnt); end
        n_cmp++; if (rx_last !== 8'h5C) begin n_bad++; $display("FAIL arst_rx: got %h want 5c", rx_last); end
    endtask

    initial begin
        test_reset();
        test_reset_presence();
        test_write_byte();
        test_tx_read();
        test_arm_midbyte(8'hFF, 8'h5A, 8'h81, 1'b0, 8'h81);
        test_arm_midbyte(8'h00, 8'hF3, 8'h00, 1'b1, 8'h00);
        test_reset_abort();
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
